// File: rtl/dual_capture_checker.sv
//==============================================================================
// Module      : dual_capture_checker
// Description : Counts q1/q2 disagreements over a bounded run window and
//               presents the result through a valid/ready report.
//               Optional: DUAL_CAPTURE_STICKY_FAIL_EN makes fail sticky to reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dual_capture_checker #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             q1,
    input  logic             q2,
    output logic             busy,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic             rpt_any,
    output logic [CNT_W-1:0] rpt_first,
    output logic [CNT_W-1:0] rpt_last,
    output logic [ERR_W-1:0] rpt_errs,
    output logic             fail
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CYC_MAX = '1;
    localparam logic [ERR_W-1:0] c_ERR_MAX = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_first;
    logic [CNT_W-1:0] r_last;
    logic [ERR_W-1:0] r_errs;
    logic             r_any;
    logic             r_fail;
    logic             w_mismatch;
    logic             w_run_end;
    logic             w_run_enter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mismatch   = q1 ^ q2;
        w_run_end    = stop || (r_cyc == c_CYC_MAX);
        w_run_enter  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                    w_run_enter  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_run_end) begin
                    w_state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                // rpt_valid is implied by being in this state
                if (rpt_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc   <= '0;
            r_first <= '0;
            r_last  <= '0;
            r_errs  <= '0;
            r_any   <= 1'b0;
        end else if (w_run_enter) begin
            r_cyc   <= '0;
            r_first <= '0;
            r_errs  <= '0;
            r_any   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_last <= r_cyc;
            if (!w_run_end) begin
                r_cyc <= r_cyc + 1'b1;
            end
            if (w_mismatch) begin
                if (r_errs != c_ERR_MAX) begin
                    r_errs <= r_errs + 1'b1;
                end
                if (!r_any) begin
                    r_first <= r_cyc;
                    r_any   <= 1'b1;
                end
            end
        end
    end

`ifdef DUAL_CAPTURE_STICKY_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail <= 1'b0;
        end else if ((r_state == S_RUN) && w_mismatch) begin
            r_fail <= 1'b1;
        end
    end
`else
    // Tracks rpt_any of the current or most recent run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail <= 1'b0;
        end else if (w_run_enter) begin
            r_fail <= 1'b0;
        end else if ((r_state == S_RUN) && w_mismatch) begin
            r_fail <= 1'b1;
        end
    end
`endif

    assign busy      = (r_state != S_IDLE);
    assign rpt_valid = (r_state == S_REPORT);
    assign rpt_any   = r_any;
    assign rpt_first = r_first;
    assign rpt_last  = r_last;
    assign rpt_errs  = r_errs;
    assign fail      = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_dual_capture_checker.sv
//==============================================================================
// Module      : tb_dual_capture_checker
// Description : Directed self-checking bench; two instances share stimulus,
//               one with a wide error counter and one with ERR_W=3.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dual_capture_checker;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             q1;
    logic             q2;
    logic             rpt_ready;
    logic             busy_a, valid_a, any_a, fail_a;
    logic [CNT_W-1:0] first_a, last_a;
    logic [7:0]       errs_a;
    logic             busy_b, valid_b, any_b, fail_b;
    logic [CNT_W-1:0] first_b, last_b;
    logic [2:0]       errs_b;

    int n_checks = 0;
    int n_errors = 0;

`ifdef DUAL_CAPTURE_STICKY_FAIL_EN
    localparam logic c_STICKY = 1'b1;
`else
    localparam logic c_STICKY = 1'b0;
`endif

    dual_capture_checker #(.CNT_W(CNT_W), .ERR_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .q1(q1), .q2(q2),
        .busy(busy_a), .rpt_valid(valid_a), .rpt_ready(rpt_ready),
        .rpt_any(any_a), .rpt_first(first_a), .rpt_last(last_a),
        .rpt_errs(errs_a), .fail(fail_a)
    );

    dual_capture_checker #(.CNT_W(CNT_W), .ERR_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .q1(q1), .q2(q2),
        .busy(busy_b), .rpt_valid(valid_b), .rpt_ready(rpt_ready),
        .rpt_any(any_b), .rpt_first(first_b), .rpt_last(last_b),
        .rpt_errs(errs_b), .fail(fail_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_report(input string tag, input logic any, input int first,
                              input int last, input int errs);
        chk({tag, "_valid"}, valid_a, 1);
        chk({tag, "_busy"},  busy_a,  1);
        chk({tag, "_any"},   any_a,   any);
        chk({tag, "_first"}, first_a, first);
        chk({tag, "_last"},  last_a,  last);
        chk({tag, "_errs"},  errs_a,  errs);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; q1 = 1'b0; q2 = 1'b0; rpt_ready = 1'b0;
        #2;
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_any", any_a, 0);
        chk("rst_fail", fail_a, 0);
        chk("rst_first", first_a, 0);
        chk("rst_last", last_a, 0);
        chk("rst_errs", errs_a, 0);
        step();
        rst_n = 1'b1;
        step();

        // Clean run: 10 samples, stop on the 10th
        start = 1'b1;
        step();
        start = 1'b0;
        chk("clean_busy", busy_a, 1);
        chk("clean_valid_early", valid_a, 0);
        for (int i = 0; i < 10; i++) begin
            q1 = i[1]; q2 = i[1];
            stop = (i == 9);
            step();
        end
        stop = 1'b0;
        chk_report("clean", 1'b0, 0, 9, 0);
        chk("clean_fail", fail_a, 0);
        rpt_ready = 1'b1;
        step();
        rpt_ready = 1'b0;
        chk("clean_ack_valid", valid_a, 0);
        chk("clean_ack_busy", busy_a, 0);

        // Mismatches at indices 3 and 7 of a 12-sample run
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            q1 = i[0];
            q2 = i[0] ^ ((i == 3) || (i == 7));
            stop = (i == 11);
            step();
        end
        stop = 1'b0;
        chk_report("mism", 1'b1, 3, 11, 2);
        chk("mism_fail", fail_a, 1);
        chk("mism_errs_b", errs_b, 2);

        // Backpressure: report held, start and mismatching data ignored
        for (int i = 0; i < 5; i++) begin
            q1 = 1'b1; q2 = 1'b0;
            start = (i == 2);
            stop = (i == 3);
            step();
            chk_report("bp", 1'b1, 3, 11, 2);
        end
        start = 1'b0; stop = 1'b0;
        rpt_ready = 1'b1;
        step();
        rpt_ready = 1'b0;
        chk("bp_ack_valid", valid_a, 0);
        chk("bp_ack_busy", busy_a, 0);
        chk("bp_ack_errs", errs_a, 2);

        // Clean run after a failing one: fail depends on stickiness
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sticky_run_fail", fail_a, c_STICKY);
        for (int i = 0; i < 3; i++) begin
            q1 = 1'b0; q2 = 1'b0;
            stop = (i == 2);
            step();
            chk("sticky_fail_during", fail_a, c_STICKY);
        end
        stop = 1'b0;
        chk_report("sticky", 1'b0, 0, 2, 0);
        rpt_ready = 1'b1;
        step();
        chk("sticky_ack_valid", valid_a, 0);

        // Window limit: ready held high, never stop, mismatch every edge
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            q1 = 1'b1; q2 = 1'b0;
            step();
            if (i == 14) chk("win_valid_early", valid_a, 0);
        end
        chk_report("win", 1'b1, 0, 15, 16);
        chk("win_errs_b_sat", errs_b, 7);
        chk("win_last_b", last_b, 15);
        chk("win_fail", fail_a, 1);
        step();
        chk("win_ack_valid", valid_a, 0);
        chk("win_ack_busy", busy_a, 0);
        rpt_ready = 1'b0;

        // Reset mid-run at index 4 after two mismatches
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q1 = 1'b0;
            q2 = (i == 1) || (i == 2);
            step();
        end
        chk("pre_rst_errs", errs_a, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_valid", valid_a, 0);
        chk("mid_rst_any", any_a, 0);
        chk("mid_rst_fail", fail_a, 0);
        chk("mid_rst_first", first_a, 0);
        chk("mid_rst_last", last_a, 0);
        chk("mid_rst_errs", errs_a, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy_a, 0);

        // start and stop together in IDLE: start wins, shortest run
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0;
        chk("ss_busy", busy_a, 1);
        chk("ss_valid", valid_a, 0);
        q1 = 1'b1; q2 = 1'b1;
        step();
        stop = 1'b0;
        chk_report("ss", 1'b0, 0, 0, 0);
        chk("ss_fail", fail_a, 0);
        rpt_ready = 1'b1;
        step();
        chk("ss_ack_valid", valid_a, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
